// File: rtl/bk_accumulator_pkg.sv
// Shared types and constants for the bk_accumulator slice.
package bk_accumulator_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // Unsigned carry-out of an add, recovered from the operand and sum MSBs.
    function automatic logic add_cout(input logic a31, input logic b31, input logic s31);
        return (a31 & b31) | ((a31 ^ b31) & ~s31);
    endfunction

endpackage

// File: rtl/bk_accumulator_if.sv
// Operand stream in, result stream out, grouped as one bus.
interface bk_accumulator_if
    import bk_accumulator_pkg::*;
#(
    parameter int unsigned CNT_W = 5
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_sum;
    logic              m_carry;
    logic              m_trunc;
    logic [CNT_W-1:0]  m_count;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_sum, m_carry, m_trunc, m_count
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_sum, m_carry, m_trunc, m_count
    );

endinterface

// File: rtl/bk_accumulator_bk.sv
// BK: purely combinational 32-bit Brent-Kung prefix adder, no carry-in.
module bk_accumulator_bk
    import bk_accumulator_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    localparam int unsigned LVLS = $clog2(DATA_W);

    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] pp;
    logic [DATA_W-1:0] gg;

    assign p = a ^ b;
    assign g = a & b;

    // Up-sweep builds power-of-two group (G,P); down-sweep fills the remaining prefixes.
    always_comb begin
        gg = g;
        pp = p;
        for (int unsigned l = 0; l < LVLS; l++) begin
            for (int unsigned i = (2 << l) - 1; i < DATA_W; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        for (int unsigned k = 0; k < LVLS - 1; k++) begin
            for (int unsigned i = 3 * (1 << (LVLS - 2 - k)) - 1; i < DATA_W;
                 i += (2 << (LVLS - 2 - k))) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << (LVLS - 2 - k))]);
            end
        end
    end

    assign sum = p ^ {gg[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/bk_accumulator.sv
// Packet accumulator: sums a valid/ready operand stream through BK and
// returns sum, sticky carry, truncation flag and operand count per packet.
module bk_accumulator
    import bk_accumulator_pkg::*;
#(
    parameter int unsigned MAX_OPS = 16
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    bk_accumulator_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OPS + 1);

    state_t            state;
    state_t            state_nxt;
    logic              rdy_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] bk_sum;
    logic              carry;
    logic              cout;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accept;
    logic              pkt_end;
    logic [DATA_W-1:0] m_sum_q;
    logic              m_carry_q;
    logic              m_trunc_q;
    logic [CNT_W-1:0]  m_count_q;

    bk_accumulator_bk bk (
        .a   (acc),
        .b   (bus.s_data),
        .sum (bk_sum)
    );

    assign cout    = add_cout(acc[DATA_W-1], bus.s_data[DATA_W-1], bk_sum[DATA_W-1]);
    assign accept  = bus.s_valid & rdy_q & ~clr;
    assign cnt_inc = count + CNT_W'(1);
    assign pkt_end = bus.s_last | (cnt_inc == CNT_W'(MAX_OPS));

    assign bus.s_ready = rdy_q;
    assign bus.m_valid = (state == DONE);
    assign bus.m_sum   = m_sum_q;
    assign bus.m_carry = m_carry_q;
    assign bus.m_trunc = m_trunc_q;
    assign bus.m_count = m_count_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (accept) state_nxt = pkt_end ? DONE : ACCUM;
            DONE:        if (bus.m_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // Ready is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            carry     <= 1'b0;
            count     <= '0;
            m_sum_q   <= '0;
            m_carry_q <= 1'b0;
            m_trunc_q <= 1'b0;
            m_count_q <= '0;
        end else if (clr) begin
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if (state == DONE) begin
            if (bus.m_ready) begin
                acc   <= '0;
                carry <= 1'b0;
                count <= '0;
            end
        end else if (accept) begin
            acc   <= bk_sum;
            carry <= carry | cout;
            count <= cnt_inc;
            if (pkt_end) begin
                m_sum_q   <= bk_sum;
                m_carry_q <= carry | cout;
                m_count_q <= cnt_inc;
                m_trunc_q <= ~bus.s_last;
            end
        end
    end

endmodule
